// File: rtl/awmc_pkg.sv
// Shared codes for the washing-machine front panel: controller stage codes
// and the panel FSM state encoding shown on the display.
package awmc_pkg;

  localparam logic [2:0] STG_IDLE  = 3'd0;
  localparam logic [2:0] STG_FILL  = 3'd1;
  localparam logic [2:0] STG_WASH  = 3'd2;
  localparam logic [2:0] STG_RINSE = 3'd3;
  localparam logic [2:0] STG_SPIN  = 3'd4;
  localparam logic [2:0] STG_DRAIN = 3'd5;

  typedef enum logic [2:0] {
    P_IDLE   = 3'd0,
    P_ARM    = 3'd1,
    P_RUN    = 3'd2,
    P_PAUSED = 3'd3,
    P_DONE   = 3'd4,
    P_FAULT  = 3'd5
  } panel_state_e;

endpackage

// File: rtl/awmc_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a one-cycle
// press event on each accepted 0->1 change. Raw edge to event is
// 2 + DEBOUNCE_CYCLES cycles.
module awmc_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic press_o
);
  import awmc_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q, level_q, press_q;
  logic [CW-1:0] cnt_q;

  // Synchronize, then accept a new level once it has differed from the
  // accepted one for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        press_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/awmc_panel_ctrl.sv
// Front-panel command initiator: debounced start/pause buttons gated by the
// door sensor drive the washing controller; tracks stage/done for door lock,
// completion buzzer and sticky fault.
module awmc_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int START_PULSE     = 2,
  parameter int ARM_TIMEOUT     = 64,
  parameter int BUZZ_CYCLES     = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_raw,
  input  logic       btn_pause_raw,
  input  logic       door_closed,
  input  logic [2:0] stage,
  input  logic       done,
  output logic       start,
  output logic       pause,
  output logic       door_lock,
  output logic       buzzer,
  output logic       err,
  output logic [2:0] panel_state
);
  import awmc_pkg::*;

  localparam int PW = $clog2(START_PULSE + 1);
  localparam int TW = $clog2(ARM_TIMEOUT + 1);
  localparam int BW = $clog2(BUZZ_CYCLES + 1);
  localparam logic [PW-1:0] PULSE_INIT = PW'(START_PULSE - 1);
  localparam logic [TW-1:0] TMO_INIT   = TW'(ARM_TIMEOUT - 1);
  localparam logic [BW-1:0] BUZZ_INIT  = BW'(BUZZ_CYCLES - 1);

  logic          start_evt, pause_evt;
  panel_state_e  state_q, state_d;
  logic          start_q, pause_q, door_lock_q, buzzer_q, err_q;
  logic [PW-1:0] pulse_q;
  logic [TW-1:0] tmo_q;
  logic [BW-1:0] buzz_q;
  logic          door_guarded;

  awmc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .reset(reset), .raw_i(btn_start_raw), .press_o(start_evt)
  );

  awmc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk(clk), .reset(reset), .raw_i(btn_pause_raw), .press_o(pause_evt)
  );

  assign door_guarded = (state_q == P_ARM) || (state_q == P_RUN) || (state_q == P_PAUSED);

  // Next-state selection; an open door while the drum is in use beats everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      P_IDLE:   if (start_evt && door_closed) state_d = P_ARM;
      P_ARM:    if (stage != STG_IDLE) state_d = P_RUN;
                else if (tmo_q == '0) state_d = P_FAULT;
      P_RUN:    if (done) state_d = P_DONE;
                else if (pause_evt) state_d = P_PAUSED;
      P_PAUSED: if (start_evt || pause_evt) state_d = P_RUN;
      P_DONE:   if (buzz_q == '0) state_d = P_IDLE;
      P_FAULT:  state_d = P_FAULT;
      default:  state_d = P_IDLE;
    endcase
    if (door_guarded && !door_closed) state_d = P_FAULT;
  end

  // State register, timers and outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= P_IDLE;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      door_lock_q <= 1'b0;
      buzzer_q    <= 1'b0;
      err_q       <= 1'b0;
      pulse_q     <= '0;
      tmo_q       <= '0;
      buzz_q      <= '0;
    end else begin
      state_q     <= state_d;
      door_lock_q <= (state_d == P_ARM) || (state_d == P_RUN) || (state_d == P_PAUSED);
      pause_q     <= (state_d == P_PAUSED) || (state_d == P_FAULT);
      err_q       <= (state_d == P_FAULT);
      buzzer_q    <= (state_d == P_DONE);

      if (state_d == P_ARM && state_q != P_ARM) begin
        start_q <= 1'b1;
        pulse_q <= PULSE_INIT;
        tmo_q   <= TMO_INIT;
      end else if (state_d == P_ARM) begin
        start_q <= (pulse_q != '0);
        if (pulse_q != '0) pulse_q <= pulse_q - PW'(1);
        if (tmo_q != '0) tmo_q <= tmo_q - TW'(1);
      end else begin
        start_q <= 1'b0;
        pulse_q <= '0;
      end

      if (state_d == P_DONE && state_q != P_DONE) buzz_q <= BUZZ_INIT;
      else if (state_q == P_DONE && buzz_q != '0) buzz_q <= buzz_q - BW'(1);
    end
  end

  assign start       = start_q;
  assign pause       = pause_q;
  assign door_lock   = door_lock_q;
  assign buzzer      = buzzer_q;
  assign err         = err_q;
  assign panel_state = state_q;

endmodule
